// File: rtl/conv1_layer1_res_collect_pkg.sv
// Shared definitions for the conv1 layer-1 datapath stages.
package conv1_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_VEC_LEN = 64;

  typedef logic [DEF_DATA_W*DEF_VEC_LEN-1:0] vec_t;

  // Negative two's-complement values clamp to zero (MSB test).
  function automatic logic [DEF_DATA_W-1:0] relu(input logic [DEF_DATA_W-1:0] x);
    return x[DEF_DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/conv1_layer1_res_collect_bank.sv
// One VEC_LEN x DATA_W result bank: indexed write, whole bank readable as a packed vector.
module res_bank
  import conv1_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IDX_W-1:0]          widx,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W*VEC_LEN-1:0] rd_vec
);

  logic [DATA_W-1:0] mem_q [VEC_LEN];
  logic [DATA_W-1:0] mem_d [VEC_LEN];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx] = wdata;
  end

  // Data is deliberately left unreset; validity is tracked by the full flags.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar k = 0; k < VEC_LEN; k++) begin : g_rd
    assign rd_vec[k*DATA_W +: DATA_W] = mem_q[k];
  end

endmodule

// File: rtl/conv1_layer1_res_collect.sv
// Collects serial adder-tree results into ping-pong banks and hands off full vectors.
module conv1_layer1_res_collect
  import conv1_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      data_v,
  input  logic [DATA_W-1:0]         in_res,
  output logic [DATA_W*VEC_LEN-1:0] out_vec,
  output logic                      out_v,
  input  logic                      out_ready,
  output logic                      overrun,
  output logic [15:0]               vec_cnt
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       vec_cnt_q, vec_cnt_d;

  logic [1:0]        we;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              hs;
  logic [DATA_W*VEC_LEN-1:0] bank_vec0, bank_vec1;

  always_comb begin
    wr_data   = (RELU_EN && in_res[DATA_W-1]) ? '0 : in_res;
    wr_en     = data_v && !full_q[wr_bank_q] && !start;
    hs        = full_q[rd_bank_q] && out_ready && !start;
    we        = '0;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    overrun_d = overrun_q;
    vec_cnt_d = vec_cnt_q;

    if (start) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_idx_d  = '0;
      overrun_d = 1'b0;
      vec_cnt_d = '0;
    end else begin
      if (wr_en) begin
        we[wr_bank_q] = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_idx_d          = '0;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end
      if (data_v && full_q[wr_bank_q]) overrun_d = 1'b1;
      // A write only targets a non-full bank and a handshake only a full one,
      // so both updates to full_d never hit the same bit.
      if (hs) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        vec_cnt_d         = vec_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      overrun_q <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      overrun_q <= overrun_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  res_bank #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .IDX_W(IDX_W)) u_bank0 (
    .clk    (clk),
    .we     (we[0]),
    .widx   (wr_idx_q),
    .wdata  (wr_data),
    .rd_vec (bank_vec0)
  );

  res_bank #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .IDX_W(IDX_W)) u_bank1 (
    .clk    (clk),
    .we     (we[1]),
    .widx   (wr_idx_q),
    .wdata  (wr_data),
    .rd_vec (bank_vec1)
  );

  assign out_vec = rd_bank_q ? bank_vec1 : bank_vec0;
  assign out_v   = full_q[rd_bank_q];
  assign overrun = overrun_q;
  assign vec_cnt = vec_cnt_q;

endmodule

// File: doc/conv1_layer1_res_collect.md
# conv1_layer1_res_collect

Downstream stage of the conv1 layer-1 dense datapath. Consumes the serial 16-bit results of the 25-wise adder tree (one per `data_v` pulse). Applies optional ReLU and packs `VEC_LEN` consecutive results into a wide vector for the 1×64 parallel multiplier. Uses a ping-pong pair of banks so the adder tree, which has no backpressure, can keep streaming while the consumer drains the previous vector.

## Interface
Parameters:
- `DATA_W`, 16: width of one adder-tree result, signed two's complement.
- `VEC_LEN`, 64: results packed per output vector.
- `RELU_EN`, 1: 1 clamps negative results to 0; 0 passes them unchanged.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that starts a new layer pass and acts as a synchronous clear.
- `data_v`, in, 1: `in_res` is valid this cycle.
- `in_res`, in, `DATA_W`: adder-tree result.
- `out_vec`, out, `DATA_W*VEC_LEN`: packed vector; element k is at `[k*DATA_W +: DATA_W]`.
- `out_v`, out, 1: `out_vec` holds a complete vector.
- `out_ready`, in, 1: consumer accepts `out_vec` this cycle.
- `overrun`, out, 1: sticky flag; a result was dropped because both banks were full.
- `vec_cnt`, out, 16: number of vectors handed off since the last `start`/`rst`; wraps at 2^16.

## Operation
- State:
  - Two banks B0/B1, each `VEC_LEN`×`DATA_W`.
  - `full[1:0]`.
  - `wr_bank` and `wr_idx` (0..`VEC_LEN`-1).
  - `rd_bank`.
- Write:
  - On `data_v` with `full[wr_bank]`==0: store f(`in_res`) at `wr_idx` of `wr_bank`.
  - f = ReLU when `RELU_EN`=1 (negative values become 0, MSB test); otherwise identity.
  - If `wr_idx`==`VEC_LEN`-1: set `full[wr_bank]`, toggle `wr_bank`, set `wr_idx` to 0. Otherwise increment `wr_idx`.
- Overrun:
  - On `data_v` with `full[wr_bank]`==1: discard the sample, set `overrun`, leave `wr_idx` unchanged.
- Read:
  - `out_v` = `full[rd_bank]`.
  - `out_vec` = contents of `rd_bank`.
  - Handshake fires when `out_v && out_ready`: clear `full[rd_bank]`, toggle `rd_bank`, increment `vec_cnt`.
  - `out_ready` while `out_v`=0 has no effect.
- Per-bank states: FILL (full=0, may be written) → FULL on the last write → FILL on handshake.
- Simultaneous fill-complete of one bank and handshake on the other in the same cycle: both take effect.
- A bank is never written while FULL.
- `start` or `rst`:
  - Clears `full`, `wr_bank`, `wr_idx`, `rd_bank`, `overrun`, `vec_cnt`.
  - Has priority over a `data_v` or handshake in the same cycle; those are ignored.
  - A `start` mid-vector discards the partial vector.
- Bank data is not cleared by reset. `out_vec` content is don't-care while `out_v`=0.

## Timing
- Reset values:
  - `out_v`=0, `overrun`=0, `vec_cnt`=0.
  - `out_vec` is undefined; the bench must check it only while `out_v`=1.
- Latency: the last element is accepted at edge N; `out_v`=1 and `out_vec` is complete after edge N (visible in cycle N+1).
- `out_vec` and `out_v` are registered outputs with no combinational path from `data_v`/`in_res`.
- `out_v` drops in the cycle after the handshake edge, unless the other bank is already FULL, in which case `out_v` stays 1 and `out_vec` switches bank.
- Sustained throughput: one input per cycle with no loss, provided the consumer accepts each vector within `VEC_LEN` cycles of `out_v` rising.

## Structure
- Shared package `conv1_pkg`:
  - `DATA_W` and `VEC_LEN` defaults.
  - Typedef of the packed vector.
  - A `relu` function for reuse by other conv1 stages.
- One sub-module, `res_bank`:
  - Single `VEC_LEN`×`DATA_W` register bank with write-enable/index and a packed read port.
  - Instantiated twice.
- Control (pointers, full flags, overrun, counter) lives in the top block.

## Test plan
- Reset, then 64 `data_v` pulses with values 0..63, `out_ready`=1 → `out_v` rises one cycle after the 64th write; element k == k; handshake occurs; `vec_cnt`=1.
- `RELU_EN`=1, inputs alternating -5 (0xFFFB) and 7 → even elements 0, odd elements 7. With `RELU_EN`=0 → even elements 0xFFFB.
- Continuous 128 inputs with `out_ready`=0 → both banks FULL, `out_v` stays 1. A 129th input → `overrun`=1 and is dropped. Raise `out_ready` → vectors 0..63 then 64..127 are delivered back-to-back; `vec_cnt`=2.
- Bank 1 completes fill in the same cycle that bank 0 is handshaken → no data loss; `out_v` stays 1; `out_vec` shows bank 1 contents next cycle.
- `start` after 30 inputs, with `data_v` asserted in the same cycle → `wr_idx`=0, `overrun`=0, `vec_cnt`=0, that sample ignored. The next 64 inputs form vector 0 exactly.
